rej_sampler_gen: RTL and testbench
==================================

REJ_SAMPLER_GEN -- requirements
Module: rej_sampler_gen

Interface
REQ-001 Parameter BLOCK_BITS, default 1344, meaning bits per squeezed block (SHAKE128 rate).
REQ-002 Parameter CHUNK_BITS, default 24, meaning uniform-mode candidate stride.
REQ-003 Parameter COEFF_W, default 23, meaning coefficient width.
REQ-004 Parameter Q, default 8380417, meaning modulus.
REQ-005 Parameter N_COEFF, default 256, meaning coefficients per polynomial.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 i_start  in  1  single-cycle start pulse.
REQ-009 i_mode  in  2  00 uniform, 01 eta=2, 10 eta=4, 11 reserved.
REQ-010 o_busy  out  1  high from accepted start until o_done.
REQ-011 o_blk_req  out  1  one-cycle pulse requesting next squeeze block.
REQ-012 i_blk_valid  in  1  block available.
REQ-013 o_blk_ready  out  1  block may be accepted.
REQ-014 i_blk_data  in  BLOCK_BITS  squeezed block, bit 0 = first stream bit.
REQ-015 o_coeff_valid  out  1  coefficient available.
REQ-016 i_coeff_ready  in  1  downstream accepts coefficient.
REQ-017 o_coeff_data  out  COEFF_W  coefficient, always < Q.
REQ-018 o_coeff_idx  out  clog2(N_COEFF)  index of presented coefficient.
REQ-019 o_done  out  1  one-cycle completion pulse.

Function
REQ-020 States SHALL be IDLE, REQ, WAIT_BLK, PROCESS, DONE.
REQ-021 IDLE: i_start with i_mode != 11 SHALL latch mode, clear count, go REQ; i_start with mode 11 or while busy SHALL be ignored.
REQ-022 REQ: SHALL pulse o_blk_req one cycle, go WAIT_BLK.
REQ-023 WAIT_BLK: o_blk_ready high; on i_blk_valid & o_blk_ready SHALL load buffer, zero bit pointer, go PROCESS next cycle.
REQ-024 PROCESS SHALL evaluate at most one candidate per cycle at bit pointer, advancing pointer by stride (CHUNK_BITS uniform, 4 eta).
REQ-025 Uniform: candidate = buffer[ptr +: CHUNK_BITS] masked to low COEFF_W bits; accept iff < Q; output candidate.
REQ-026 Eta=2: candidate = 4-bit nibble b; accept iff b < 15; output 2 - (b mod 5) reduced into [0,Q) (negative v -> Q+v).
REQ-027 Eta=4: accept iff b < 9; output 4 - b reduced into [0,Q).
REQ-028 Low nibble of each byte SHALL be evaluated before high nibble.
REQ-029 When ptr + stride > BLOCK_BITS remaining bits SHALL be discarded and state SHALL go REQ.
REQ-030 Output register: accepted candidate SHALL raise o_coeff_valid with data/idx; while valid & !ready, data/idx/valid SHALL hold and PROCESS SHALL stall.
REQ-031 Coefficient counted on valid & ready only; idx increments per handshake.
REQ-032 Handshake of coefficient N_COEFF-1 SHALL go DONE; remaining block bits discarded, no further o_blk_req.
REQ-033 DONE: o_done pulse one cycle, o_busy low, return IDLE.
REQ-034 Rejected candidates SHALL produce no output and no stall.

Reset
REQ-035 rst_n low at a clock edge SHALL force IDLE, all outputs 0, count/pointer/buffer 0, including mid-operation.
REQ-036 First cycle after reset release SHALL accept i_start.

Structure
REQ-037 Mode encodings, state encoding and default Q/N_COEFF constants SHALL live in shared package keygen_pkg.
REQ-038 Candidate test and eta mapping SHALL be sub-module rej_candidate_eval (combinational: mode, raw bits -> accept, value).

Verification
REQ-039 Uniform, all-zero blocks, ready=1 -> 256 coefficients of 0, exactly 5 o_blk_req (56 per block), single o_done.
REQ-040 Uniform, first block all-ones -> zero coefficients from it (0x7FFFFF >= Q), second o_blk_req issued.
REQ-041 Eta=2, byte 0xFE repeated -> coeffs Q-2 only (nibble 14 accepted, 15 rejected), 336 candidates/block.
REQ-042 Eta=4, byte 0x98 -> coeff Q-4 (nibble 8), nibble 9 rejected.
REQ-043 Ready held low 10 cycles mid-run -> data/idx stable, no idx skip, total 256.
REQ-044 rst_n low during PROCESS -> next cycle all outputs 0, IDLE; fresh start reproduces golden sequence.

Source files
------------

// File: rtl/keygen_pkg.sv
// keygen_pkg: shared encodings and default constants for the key-generation samplers
package keygen_pkg;

   typedef enum logic [1:0] {
      MODE_UNIFORM = 2'b00,
      MODE_ETA2    = 2'b01,
      MODE_ETA4    = 2'b10,
      MODE_RSVD    = 2'b11
   } mode_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT_BLK,
      S_PROCESS,
      S_DONE
   } state_t;

   localparam int KG_Q       = 8380417;
   localparam int KG_N_COEFF = 256;

endpackage

// File: rtl/rej_candidate_eval.sv
// rej_candidate_eval: combinational accept test and value mapping for one sampler candidate
module rej_candidate_eval
   import keygen_pkg::*;
#(
   parameter int CHUNK_BITS = 24,
   parameter int COEFF_W    = 23,
   parameter int Q          = KG_Q
) (
   input  mode_t                  mode,
   input  logic [CHUNK_BITS-1:0]  raw,
   output logic                   accept,
   output logic [COEFF_W-1:0]     value
);

   localparam logic [COEFF_W-1:0] QW = COEFF_W'(Q);

   logic [3:0]         b;
   logic [2:0]         m5;
   logic [COEFF_W-1:0] u;
   logic [COEFF_W-1:0] e;
   logic [COEFF_W-1:0] d;
   logic               unused_bits;

   assign unused_bits = ^raw[CHUNK_BITS-1:COEFF_W];

   // eta value is e - d, wrapped to Q + e - d when negative
   always_comb begin
      b      = raw[3:0];
      m5     = 3'(b % 4'd5);
      u      = raw[COEFF_W-1:0];
      e      = (mode == MODE_ETA2) ? COEFF_W'(2) : COEFF_W'(4);
      d      = (mode == MODE_ETA2) ? COEFF_W'(m5) : COEFF_W'(b);
      accept = (mode == MODE_UNIFORM) ? (u < QW) :
               (mode == MODE_ETA2)    ? (b != 4'd15) :
               (mode == MODE_ETA4)    ? (b < 4'd9) : 1'b0;
      value  = (mode == MODE_UNIFORM) ? u : (d <= e) ? e - d : QW + e - d;
   end

endmodule

// File: rtl/rej_sampler_gen.sv
// rej_sampler_gen: rejection sampler turning squeezed blocks into N_COEFF coefficients mod Q
module rej_sampler_gen
   import keygen_pkg::*;
#(
   parameter int BLOCK_BITS = 1344,
   parameter int CHUNK_BITS = 24,
   parameter int COEFF_W    = 23,
   parameter int Q          = KG_Q,
   parameter int N_COEFF    = KG_N_COEFF
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_start,
   input  logic [1:0]                   i_mode,
   output logic                         o_busy,
   output logic                         o_blk_req,
   input  logic                         i_blk_valid,
   output logic                         o_blk_ready,
   input  logic [BLOCK_BITS-1:0]        i_blk_data,
   output logic                         o_coeff_valid,
   input  logic                         i_coeff_ready,
   output logic [COEFF_W-1:0]           o_coeff_data,
   output logic [$clog2(N_COEFF)-1:0]   o_coeff_idx,
   output logic                         o_done
);

   localparam int IW = $clog2(N_COEFF);
   localparam int PW = $clog2(BLOCK_BITS + 1);

   state_t                state, state_nx;
   mode_t                 mode_q;
   logic [BLOCK_BITS-1:0] buf_q;
   logic [PW-1:0]         ptr;
   logic [PW:0]           stride;
   logic [PW:0]           ptr_nx;
   logic                  acc;
   logic [COEFF_W-1:0]    val;
   logic                  hs, stall, last, blk_end, start_ok, eval_en;

   rej_candidate_eval #(
      .CHUNK_BITS (CHUNK_BITS),
      .COEFF_W    (COEFF_W),
      .Q          (Q)
   ) u_eval (
      .mode   (mode_q),
      .raw    (buf_q[CHUNK_BITS-1:0]),
      .accept (acc),
      .value  (val)
   );

   // handshake, stall and end-of-block decisions for the current cycle
   always_comb begin
      stride   = (mode_q == MODE_UNIFORM) ? (PW+1)'(CHUNK_BITS) : (PW+1)'(4);
      ptr_nx   = {1'b0, ptr} + stride;
      hs       = o_coeff_valid && i_coeff_ready;
      stall    = o_coeff_valid && !i_coeff_ready;
      last     = hs && (o_coeff_idx == IW'(N_COEFF - 1));
      blk_end  = ptr_nx > (PW+1)'(BLOCK_BITS);
      start_ok = i_start && (i_mode != MODE_RSVD);
      eval_en  = (state == S_PROCESS) && !last && !stall && !blk_end;
   end

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // next state and state-decoded outputs; last handshake wins over block end
   always_comb begin
      state_nx    = state;
      o_busy      = (state == S_REQ) || (state == S_WAIT_BLK) || (state == S_PROCESS);
      o_blk_req   = (state == S_REQ);
      o_blk_ready = (state == S_WAIT_BLK);
      o_done      = (state == S_DONE);
      case (state)
         S_IDLE:     state_nx = start_ok ? S_REQ : S_IDLE;
         S_REQ:      state_nx = S_WAIT_BLK;
         S_WAIT_BLK: state_nx = i_blk_valid ? S_PROCESS : S_WAIT_BLK;
         S_PROCESS:  state_nx = last ? S_DONE : stall ? S_PROCESS : blk_end ? S_REQ : S_PROCESS;
         S_DONE:     state_nx = S_IDLE;
         default:    state_nx = S_IDLE;
      endcase
   end

   // block buffer shifts out consumed bits so the candidate is always at bit 0
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mode_q        <= MODE_UNIFORM;
         buf_q         <= '0;
         ptr           <= '0;
         o_coeff_valid <= 1'b0;
         o_coeff_data  <= '0;
         o_coeff_idx   <= '0;
      end else begin
         if (state == S_IDLE && start_ok) begin
            mode_q      <= mode_t'(i_mode);
            o_coeff_idx <= '0;
         end
         if (state == S_WAIT_BLK && i_blk_valid) begin
            buf_q <= i_blk_data;
            ptr   <= '0;
         end else if (eval_en) begin
            buf_q <= buf_q >> stride;
            ptr   <= ptr_nx[PW-1:0];
         end
         if (hs) o_coeff_idx <= o_coeff_idx + IW'(1);
         o_coeff_valid <= (eval_en && acc) ? 1'b1 : hs ? 1'b0 : o_coeff_valid;
         if (eval_en && acc) o_coeff_data <= val;
      end
   end

endmodule

// File: tb/tb_rej_sampler_gen.sv
// tb_rej_sampler_gen: scoreboard bench for the rejection sampler
module tb_rej_sampler_gen;
   import keygen_pkg::*;

   localparam int BB = 1344;
   localparam int CB = 24;
   localparam int CW = 23;
   localparam int QQ = 8380417;
   localparam int NC = 256;
   localparam int IW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_start = 1'b0;
   logic [1:0]    i_mode = 2'b00;
   logic          o_busy, o_blk_req, o_blk_ready, o_coeff_valid, o_done;
   logic          i_blk_valid = 1'b0;
   logic [BB-1:0] i_blk_data = '0;
   logic          i_coeff_ready = 1'b1;
   logic [CW-1:0] o_coeff_data;
   logic [IW-1:0] o_coeff_idx;

   int unsigned sb[$];
   int n_checks = 0;
   int n_errors = 0;

   rej_sampler_gen #(
      .BLOCK_BITS (BB), .CHUNK_BITS (CB), .COEFF_W (CW), .Q (QQ), .N_COEFF (NC)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_start       (i_start),
      .i_mode        (i_mode),
      .o_busy        (o_busy),
      .o_blk_req     (o_blk_req),
      .i_blk_valid   (i_blk_valid),
      .o_blk_ready   (o_blk_ready),
      .i_blk_data    (i_blk_data),
      .o_coeff_valid (o_coeff_valid),
      .i_coeff_ready (i_coeff_ready),
      .o_coeff_data  (o_coeff_data),
      .o_coeff_idx   (o_coeff_idx),
      .o_done        (o_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mix(input logic [31:0] x);
      logic [31:0] y;
      y = x * 32'h9E3779B1;
      y = y ^ (y >> 15);
      y = y * 32'h85EBCA6B;
      y = y ^ (y >> 13);
      return y;
   endfunction

   // pat: 0 zeros, 1 all-ones first block then zeros, 2 bytes 0xFE, 3 bytes 0x98, 4 pseudo-random
   function automatic logic [BB-1:0] make_block(input int pat, input int n);
      logic [BB-1:0] b;
      logic [31:0]   w;
      b = '0;
      for (int i = 0; i < BB / 8; i++) begin
         w = mix(32'(n * 1000 + i + 7));
         b[8*i +: 8] = (pat == 1) ? ((n == 0) ? 8'hFF : 8'h00) :
                       (pat == 2) ? 8'hFE :
                       (pat == 3) ? 8'h98 :
                       (pat == 4) ? w[7:0] : 8'h00;
      end
      return b;
   endfunction

   // reference sampler: every accepted value of a block, in stream order
   task automatic model_block(input logic [BB-1:0] b, input int m);
      int unsigned c;
      int          nib, v;
      if (m == 0) begin
         for (int i = 0; i < BB / CB; i++) begin
            c = 32'(b[CB*i +: CW]);
            if (c < QQ) sb.push_back(c);
         end
      end else begin
         for (int i = 0; i < BB / 4; i++) begin
            nib = int'(b[4*i +: 4]);
            if (m == 1 && nib < 15) begin
               v = 2 - (nib % 5);
               sb.push_back(v < 0 ? QQ + v : v);
            end
            if (m == 2 && nib < 9) begin
               v = 4 - nib;
               sb.push_back(v < 0 ? QQ + v : v);
            end
         end
      end
   endtask

   // bp: 0 always ready, 1 ready low 10 cycles at handshake 100, 2 random ready
   task automatic run(input int m, input int pat, input int bp, input int abort_at,
                      input int exp_req, input string nm);
      logic [BB-1:0] cur_blk;
      logic [CW-1:0] prev_data;
      logic [IW-1:0] prev_idx;
      logic          prev_valid, prev_ready;
      int            n_hs, n_req, n_done, blk_no, low_cnt;
      bit            done_seen, stop;
      int unsigned   e;
      cur_blk = '0; prev_data = '0; prev_idx = '0; prev_valid = 0; prev_ready = 1;
      n_hs = 0; n_req = 0; n_done = 0; blk_no = 0; low_cnt = 0; done_seen = 0; stop = 0;
      sb.delete();
      i_coeff_ready = 1'b1;
      i_start = 1'b1;
      i_mode = 2'(m);
      @(negedge clk);
      i_start = 1'b0;
      check({nm, "_busy_after_start"}, 32'(o_busy), 1);
      for (int cyc = 0; cyc < 20000 && !stop; cyc++) begin
         if (o_blk_req) begin
            cur_blk = make_block(pat, blk_no);
            model_block(cur_blk, m);
            blk_no++;
            n_req++;
         end
         i_blk_valid = o_blk_ready;
         i_blk_data  = cur_blk;
         if (bp == 1 && n_hs == 100 && low_cnt < 10) begin
            i_coeff_ready = 1'b0;
            low_cnt++;
         end else begin
            i_coeff_ready = (bp == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
         if (prev_valid && !prev_ready) begin
            check({nm, "_stall_valid"}, 32'(o_coeff_valid), 1);
            check({nm, "_stall_data"}, 32'(o_coeff_data), 32'(prev_data));
            check({nm, "_stall_idx"}, 32'(o_coeff_idx), 32'(prev_idx));
         end
         if (o_coeff_valid && i_coeff_ready) begin
            if (sb.size() == 0) begin
               check({nm, "_unexpected_coeff"}, 32'(o_coeff_data), 32'hFFFFFFFF);
            end else begin
               e = sb.pop_front();
               check({nm, "_data"}, 32'(o_coeff_data), e);
            end
            check({nm, "_idx"}, 32'(o_coeff_idx), 32'(n_hs % NC));
            n_hs++;
         end
         prev_valid = o_coeff_valid;
         prev_ready = i_coeff_ready;
         prev_data  = o_coeff_data;
         prev_idx   = o_coeff_idx;
         if (o_done) begin
            n_done++;
            done_seen = 1;
            check({nm, "_busy_at_done"}, 32'(o_busy), 0);
            stop = 1;
         end
         if (abort_at > 0 && n_hs == abort_at) stop = 1;
         if (!stop) @(negedge clk);
      end
      i_blk_valid = 1'b0;
      if (abort_at == 0) begin
         check({nm, "_finished"}, 32'(done_seen), 1);
         check({nm, "_coeff_count"}, 32'(n_hs), NC);
         check({nm, "_done_count"}, 32'(n_done), 1);
         if (exp_req >= 0) check({nm, "_blk_req_count"}, 32'(n_req), 32'(exp_req));
         @(negedge clk);
         check({nm, "_done_pulse"}, 32'(o_done), 0);
         check({nm, "_idle_busy"}, 32'(o_busy), 0);
         check({nm, "_no_extra_req"}, 32'(o_blk_req), 0);
      end
   endtask

   task automatic check_all_zero(input string nm);
      check({nm, "_busy"}, 32'(o_busy), 0);
      check({nm, "_blk_req"}, 32'(o_blk_req), 0);
      check({nm, "_blk_ready"}, 32'(o_blk_ready), 0);
      check({nm, "_valid"}, 32'(o_coeff_valid), 0);
      check({nm, "_data"}, 32'(o_coeff_data), 0);
      check({nm, "_idx"}, 32'(o_coeff_idx), 0);
      check({nm, "_done"}, 32'(o_done), 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      i_start = 1'b1;
      i_mode = 2'b11;
      @(negedge clk);
      i_start = 1'b0;
      check("rsvd_busy", 32'(o_busy), 0);
      check("rsvd_blk_req", 32'(o_blk_req), 0);
      @(negedge clk);
      check("rsvd_blk_req2", 32'(o_blk_req), 0);

      run(0, 0, 0, 0, 5, "uni_zero");
      run(0, 1, 0, 0, 6, "uni_ones");
      run(1, 2, 0, 0, 2, "eta2_fe");
      run(2, 3, 0, 0, 2, "eta4_98");
      run(0, 4, 1, 0, -1, "uni_rand_bp");
      run(1, 4, 2, 0, -1, "eta2_rand");
      run(2, 4, 2, 0, -1, "eta4_rand");

      run(0, 4, 0, 20, -1, "pre_rst");
      rst_n = 1'b0;
      @(posedge clk);
      #1 check_all_zero("mid_rst");
      @(negedge clk);
      rst_n = 1'b1;
      run(0, 4, 0, 0, -1, "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
